apb_req_arbiter: RTL

Round-robin command arbiter and sequencer in front of `apb_master`. It collects transfer requests from `NUM_REQ` local requesters and grants one at a time. It drives the master's command inputs (`address`, `write_data`, `processs`, `data_size`) and watches the shared APB bus for completion. It returns read data, a done pulse and a timeout error to the granted requester. It sits between the requesters and `apb_master` in `apb_top`.

---
 rtl/apb_req_arbiter_if.sv | 40 ++++
 rtl/apb_req_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter_if.sv
// Requester, command and bus-monitor bundle for apb_req_arbiter.
// The slave view is the arbiter; the master view drives requests and taps.
interface apb_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_wr;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ*2-1:0]      req_size;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic                      err;
  logic [DATA_W-1:0]         rdata;
  logic [ADDR_W-1:0]         address;
  logic [DATA_W-1:0]         write_data;
  logic [1:0]                processs;
  logic [1:0]                data_size;
  logic                      PSEL0;
  logic                      PSEL1;
  logic                      PENABLE;
  logic                      PREADY;
  logic [DATA_W-1:0]         PRDATA;

  modport slave (
    input  req, req_wr, req_addr, req_wdata, req_size,
    input  PSEL0, PSEL1, PENABLE, PREADY, PRDATA,
    output gnt, done, err, rdata,
    output address, write_data, processs, data_size
  );

  modport master (
    output req, req_wr, req_addr, req_wdata, req_size,
    output PSEL0, PSEL1, PENABLE, PREADY, PRDATA,
    input  gnt, done, err, rdata,
    input  address, write_data, processs, data_size
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin command arbiter and sequencer in front of apb_master.
// One transfer in flight; completion is observed on the shared APB bus.
module apb_req_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input logic              PCLK,
  input logic              PRESET,
  apb_req_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               wr_q, wr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [1:0]         proc_q, proc_d;
  logic [1:0]         size_q, size_d;

  logic [ADDR_W-1:0]  addr_a  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_a [NUM_REQ];
  logic [1:0]         size_a  [NUM_REQ];

  logic               win_found;
  logic [IW-1:0]      win_idx;
  logic [IW:0]        rr_s;
  logic [IW-1:0]      rr_i;
  logic               cmpl;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = bus.req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = bus.req_wdata[g*DATA_W +: DATA_W];
    assign size_a[g]  = bus.req_size[g*2 +: 2];
  end

  assign cmpl = (bus.PSEL0 | bus.PSEL1)
              & bus.PENABLE & bus.PREADY;

  // First requester at or above ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_s      = '0;
    rr_i      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_s = {1'b0, ptr_q} + (IW+1)'(k);
      if (rr_s >= (IW+1)'(NUM_REQ))
        rr_s = rr_s - (IW+1)'(NUM_REQ);
      rr_i = rr_s[IW-1:0];
      if (!win_found && bus.req[rr_i]) begin
        win_found = 1'b1;
        win_idx   = rr_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    proc_d  = 2'b00;
    size_d  = size_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d        = S_ISSUE;
          idx_d          = win_idx;
          wr_d           = bus.req_wr[win_idx];
          addr_d         = addr_a[win_idx];
          wdata_d        = wdata_a[win_idx];
          size_d         = size_a[win_idx];
          cnt_d          = '0;
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          proc_d         = bus.req_wr[win_idx]
                         ? 2'b01 : 2'b10;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // Real completion wins over a same-cycle timeout.
        if (cmpl) begin
          state_d       = S_DONE;
          done_d[idx_q] = 1'b1;
          rdata_d       = wr_q ? '0 : bus.PRDATA;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          state_d       = S_DONE;
          done_d[idx_q] = 1'b1;
          err_d         = 1'b1;
          rdata_d       = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
        ptr_d   = (idx_q == IW'(NUM_REQ - 1))
                ? '0 : idx_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      proc_q  <= 2'b00;
      size_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      proc_q  <= proc_d;
      size_q  <= size_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.rdata      = rdata_q;
  assign bus.address    = addr_q;
  assign bus.write_data = wdata_q;
  assign bus.processs   = proc_q;
  assign bus.data_size  = size_q;
endmodule
